// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Consumed by the controller and the flush/bubble datapaths.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } stall_st_e;

  localparam int FLUSH_CYCLES_DEF = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/halt controller with perf counters
// and a consecutive-stall watchdog.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16,
  parameter int WDOG_LIMIT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall_req,
  input  logic             i_redirect,
  input  logic             i_mem_busy,
  input  logic             i_halt,
  output logic             o_pc_en,
  output logic             o_ifid_wr_en,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_pipe_freeze,
  output logic             o_halted,
  output logic             o_watchdog_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);
  localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES - 1);

  stall_st_e r_state;
  stall_st_e w_next;
  logic [3:0] r_flush_left;
  logic [3:0] w_flush_left_nx;
  logic r_halted;
  logic r_wdog_err;
  logic [WD_W-1:0] w_wdog;

  logic w_pc_en;
  logic w_ifid_wr_en;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_freeze;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_wdog_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_flush_left <= '0;
      r_halted     <= 1'b0;
      r_wdog_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_flush_left <= w_flush_left_nx;
      r_halted     <= (w_next == HALT);
      if (w_stall_inc && (w_wdog >= WD_MAX - 1'b1))
        r_wdog_err <= 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_flush_left_nx = r_flush_left;
    w_pc_en         = 1'b1;
    w_ifid_wr_en    = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_bubble   = 1'b0;
    w_pipe_freeze   = 1'b0;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    w_wdog_clr      = 1'b0;
    priority case (1'b1)
      (r_state == HALT): begin
        w_pc_en       = 1'b0;
        w_ifid_wr_en  = 1'b0;
        w_idex_bubble = 1'b1;
      end
      i_mem_busy: begin
        w_pc_en       = 1'b0;
        w_ifid_wr_en  = 1'b0;
        w_pipe_freeze = 1'b1;
      end
      i_redirect: begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_flush_inc   = 1'b1;
        w_wdog_clr    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_next          = FLUSH;
          w_flush_left_nx = FL_LOAD;
        end else begin
          w_next          = RUN;
          w_flush_left_nx = '0;
        end
      end
      (r_state == FLUSH): begin
        // stall_req is for an instruction being discarded
        w_idex_bubble   = 1'b1;
        w_wdog_clr      = 1'b1;
        w_flush_left_nx = r_flush_left - 1'b1;
        if (r_flush_left <= 4'd1) begin
          w_next          = RUN;
          w_flush_left_nx = '0;
        end
        if (i_halt)
          w_next = HALT;
      end
      i_stall_req: begin
        w_pc_en       = 1'b0;
        w_ifid_wr_en  = 1'b0;
        w_idex_bubble = 1'b1;
        w_next        = STALL;
        w_stall_inc   = 1'b1;
      end
      default: begin
        w_wdog_clr = 1'b1;
        w_next     = i_halt ? HALT : RUN;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .i_clr (1'b0),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_flush_inc),
    .i_clr (1'b0),
    .o_cnt (o_flush_cnt)
  );

  sat_counter #(.W(WD_W), .MAX(WD_MAX)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .i_clr (w_wdog_clr),
    .o_cnt (w_wdog)
  );

  assign o_pc_en        = rst_n & w_pc_en;
  assign o_ifid_wr_en   = rst_n & w_ifid_wr_en;
  assign o_ifid_flush   = ~rst_n | w_ifid_flush;
  assign o_idex_bubble  = ~rst_n | w_idex_bubble;
  assign o_pipe_freeze  = rst_n & w_pipe_freeze;
  assign o_halted       = r_halted;
  assign o_watchdog_err = r_wdog_err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: default build plus a
// CNT_W=4 build sharing the same stimulus for saturation.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic stall_req, redirect, mem_busy, halt;

  logic pc_en, ifid_wr_en, ifid_flush, idex_bubble;
  logic pipe_freeze, halted, wdog_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic pc_en4, ifid_wr_en4, ifid_flush4, idex_bubble4;
  logic pipe_freeze4, halted4, wdog_err4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_stall_req    (stall_req),
    .i_redirect     (redirect),
    .i_mem_busy     (mem_busy),
    .i_halt         (halt),
    .o_pc_en        (pc_en),
    .o_ifid_wr_en   (ifid_wr_en),
    .o_ifid_flush   (ifid_flush),
    .o_idex_bubble  (idex_bubble),
    .o_pipe_freeze  (pipe_freeze),
    .o_halted       (halted),
    .o_watchdog_err (wdog_err),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4)) u_dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_stall_req    (stall_req),
    .i_redirect     (redirect),
    .i_mem_busy     (mem_busy),
    .i_halt         (halt),
    .o_pc_en        (pc_en4),
    .o_ifid_wr_en   (ifid_wr_en4),
    .o_ifid_flush   (ifid_flush4),
    .o_idex_bubble  (idex_bubble4),
    .o_pipe_freeze  (pipe_freeze4),
    .o_halted       (halted4),
    .o_watchdog_err (wdog_err4),
    .o_stall_cnt    (stall_cnt4),
    .o_flush_cnt    (flush_cnt4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag,
                     input logic pc, wr, fl, bub, frz);
    check({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
    check({tag, ".ifid_wr_en"}, 32'(ifid_wr_en), 32'(wr));
    check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    check({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'(frz));
  endtask

  initial begin
    rst_n = 1'b0;
    stall_req = 1'b0;
    redirect = 1'b0;
    mem_busy = 1'b0;
    halt = 1'b0;
    #2;
    ctl("rst0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // idle
    repeat (5) tick();
    @(negedge clk);
    ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle.stall_cnt", 32'(stall_cnt), 0);
    check("idle.flush_cnt", 32'(flush_cnt), 0);
    check("idle.halted", 32'(halted), 0);
    check("idle.wdog", 32'(wdog_err), 0);
    tick();

    // 3-cycle hazard stall
    for (int i = 0; i < 3; i++) begin
      stall_req = 1'b1;
      @(negedge clk);
      ctl($sformatf("stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    stall_req = 1'b0;
    @(negedge clk);
    ctl("stall_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall3.stall_cnt", 32'(stall_cnt), 3);
    tick();

    // async reset while in STALL
    stall_req = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    ctl("rst_mid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_mid.stall_cnt", 32'(stall_cnt), 0);
    stall_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    ctl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // redirect pulse, masked stall in the flush shadow
    redirect = 1'b1;
    @(negedge clk);
    ctl("redir_t", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    redirect = 1'b0;
    stall_req = 1'b1;
    @(negedge clk);
    ctl("redir_t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    stall_req = 1'b0;
    @(negedge clk);
    ctl("redir_t2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("redir.flush_cnt", 32'(flush_cnt), 1);
    check("redir.stall_cnt", 32'(stall_cnt), 0);
    tick();

    // mem_busy freezes a redirect+stall pair
    for (int i = 0; i < 2; i++) begin
      mem_busy = 1'b1;
      redirect = 1'b1;
      stall_req = 1'b1;
      @(negedge clk);
      ctl($sformatf("mem%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    @(negedge clk);
    check("mem.flush_cnt", 32'(flush_cnt), 1);
    check("mem.stall_cnt", 32'(stall_cnt), 0);
    mem_busy = 1'b0;
    #1;
    ctl("mem_rel", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    redirect = 1'b0;
    stall_req = 1'b0;
    @(negedge clk);
    ctl("mem_fl", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mem2.flush_cnt", 32'(flush_cnt), 2);
    check("mem2.stall_cnt", 32'(stall_cnt), 0);
    tick();
    @(negedge clk);
    ctl("mem_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // long stall: watchdog and 4-bit saturation
    for (int i = 0; i < 70; i++) begin
      stall_req = 1'b1;
      @(negedge clk);
      if (i == 14) check("sat.cnt4_14", 32'(stall_cnt4), 14);
      if (i == 20) check("sat.cnt4_20", 32'(stall_cnt4), 15);
      if (i == 63) check("wd.before", 32'(wdog_err), 0);
      if (i == 64) check("wd.after", 32'(wdog_err), 1);
      if (i == 69) ctl("wd.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    stall_req = 1'b0;
    @(negedge clk);
    check("wd.sticky", 32'(wdog_err), 1);
    check("wd.stall_cnt", 32'(stall_cnt), 70);
    check("sat.cnt4", 32'(stall_cnt4), 15);
    ctl("wd.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // halt is terminal
    halt = 1'b1;
    @(negedge clk);
    check("halt0.halted", 32'(halted), 0);
    check("halt0.pc_en", 32'(pc_en), 1);
    tick();
    halt = 1'b0;
    @(negedge clk);
    check("halt1.halted", 32'(halted), 1);
    ctl("halt1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      redirect = 1'b1;
      stall_req = 1'b1;
      mem_busy = (i == 1);
      @(negedge clk);
      ctl($sformatf("halt_in%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    redirect = 1'b0;
    stall_req = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    check("halt.halted", 32'(halted), 1);
    check("halt.flush_cnt", 32'(flush_cnt), 2);
    check("halt.stall_cnt", 32'(stall_cnt), 70);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
